// File: rtl/spc_muldiv_if.sv
// spc_muldiv_if: sequencer bundle covering the CPU start/write-back side and the
// iterative multiply/divide datapath side; the sequencer takes the slave modport.
interface spc_muldiv_if;
  logic        start;
  logic        op;
  logic [3:0]  dp_secop;
  logic        dp_en;
  logic [15:0] dp_res;
  logic        dp_zo;
  logic        dp_vo;
  logic        dp_ho;
  logic [7:0]  y_out;
  logic [7:0]  a_out;
  logic [3:0]  flags_out;
  logic [3:0]  flags_we;
  logic        busy;
  logic        done;
  modport master (
    output start, op, dp_res, dp_zo, dp_vo, dp_ho,
    input  dp_secop, dp_en, y_out, a_out, flags_out, flags_we, busy, done
  );
  modport slave (
    input  start, op, dp_res, dp_zo, dp_vo, dp_ho,
    output dp_secop, dp_en, y_out, a_out, flags_out, flags_we, busy, done
  );
endinterface

// File: rtl/spc_muldiv_seq.sv
// spc_muldiv_seq: SPC700 MUL YA / DIV YA,X micro-sequencer driving the iterative datapath.
// Define SPC_MULDIV_PAD_EN to stretch start-to-done latency to MUL_LAT / DIV_LAT.
module spc_muldiv_seq #(
  parameter int MUL_STEPS = 8,
  parameter int DIV_STEPS = 9
`ifdef SPC_MULDIV_PAD_EN
  ,
  parameter int MUL_LAT = 11,
  parameter int DIV_LAT = 14
`endif
) (
  input logic        CLK,
  input logic        RST_N,
  input logic        CE,
  spc_muldiv_if.slave bus
);
`ifdef SPC_MULDIV_PAD_EN
  localparam int MUL_PAD = MUL_LAT - MUL_STEPS - 2;
  localparam int DIV_PAD = DIV_LAT - DIV_STEPS - 3;
  typedef enum logic [2:0] {IDLE, LOAD, STEP, WB, PAD} state_t;
`else
  typedef enum logic [2:0] {IDLE, LOAD, STEP, WB} state_t;
`endif
  state_t      state_q, state_d;
  logic        op_q, op_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        h_q, h_d;
  logic [15:0] res_q, res_d;
  logic        zo_q, zo_d;
  logic        vo_q, vo_d;
  logic [7:0]  y_q, y_d;
  logic [7:0]  a_q, a_d;
  logic        cap;
  logic        wb_entry;
  // DIV captures one cycle after its last step, when the registered quotient is final
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    h_d     = h_q;
    res_d   = res_q;
    zo_d    = zo_q;
    vo_d    = vo_q;
    cap     = 1'b0;
    if (CE) begin
      case (state_q)
        IDLE: begin
          state_d = bus.start ? LOAD : IDLE;
          op_d    = bus.start ? bus.op : op_q;
        end
        LOAD: begin
          h_d     = bus.dp_ho;
          cnt_d   = op_q ? 8'(DIV_STEPS) : 8'(MUL_STEPS);
          state_d = STEP;
        end
        STEP: begin
          cap   = op_q ? cnt_q == 8'd0 : cnt_q == 8'd1;
          cnt_d = cnt_q - 8'(cnt_q != 8'd0);
          if (cap) begin
            res_d = bus.dp_res;
            zo_d  = bus.dp_zo;
            vo_d  = bus.dp_vo;
`ifdef SPC_MULDIV_PAD_EN
            if ((op_q ? DIV_PAD : MUL_PAD) > 0) begin
              state_d = PAD;
              cnt_d   = 8'(op_q ? DIV_PAD : MUL_PAD);
            end else begin
              state_d = WB;
            end
`else
            state_d = WB;
`endif
          end
        end
`ifdef SPC_MULDIV_PAD_EN
        PAD: begin
          cnt_d   = cnt_q - 8'd1;
          state_d = cnt_q == 8'd1 ? WB : PAD;
        end
`endif
        default: state_d = IDLE;
      endcase
    end
  end
  // y/a update only on entry to WB so they hold the previous result until then
  always_comb begin
    wb_entry = state_d == WB && state_q != WB;
    y_d      = wb_entry ? res_d[15:8] : y_q;
    a_d      = wb_entry ? res_d[7:0]  : a_q;
  end
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= IDLE;
      op_q    <= 1'b0;
      cnt_q   <= 8'd0;
      h_q     <= 1'b0;
      res_q   <= 16'd0;
      zo_q    <= 1'b0;
      vo_q    <= 1'b0;
      y_q     <= 8'd0;
      a_q     <= 8'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      h_q     <= h_d;
      res_q   <= res_d;
      zo_q    <= zo_d;
      vo_q    <= vo_d;
      y_q     <= y_d;
      a_q     <= a_d;
    end
  end
  assign bus.dp_secop  = state_q == STEP ? (op_q ? 4'b1111 : 4'b1110) : 4'b0000;
  assign bus.dp_en     = CE && (state_q == LOAD || (state_q == STEP && !(op_q && cnt_q == 8'd0)));
  assign bus.busy      = state_q != IDLE;
  assign bus.done      = CE && state_q == WB;
  assign bus.flags_we  = bus.done ? (op_q ? 4'b1111 : 4'b1001) : 4'b0000;
  assign bus.flags_out = !bus.done ? 4'b0000 :
                         op_q ? {res_q[7], vo_q, h_q, zo_q} : {res_q[15], 2'b00, zo_q};
  assign bus.y_out     = y_q;
  assign bus.a_out     = a_q;
endmodule

// File: tb/tb_spc_muldiv_seq.sv
// tb_spc_muldiv_seq: directed MUL/DIV vectors against a timing-strict reference datapath;
// expected write-back bundles are queued at issue and checked by a done-driven monitor.
module tb_spc_muldiv_seq;
`ifdef SPC_MULDIV_PAD_EN
  localparam int ML = 11, DL = 14;
`else
  localparam int ML = 10, DL = 12;
`endif
  typedef struct {
    logic [7:0] y;
    logic [7:0] a;
    logic [3:0] f;
    logic [3:0] w;
    int         c;
  } exp_t;

  logic CLK = 1'b0, RST_N = 1'b0, CE = 1'b1;
  spc_muldiv_if bus();
  spc_muldiv_seq dut (.CLK(CLK), .RST_N(RST_N), .CE(CE), .bus(bus));
  always #5 CLK = ~CLK;

  int n_cmp = 0, n_bad = 0, cyc = 0, done_cnt = 0, k = 0;
  exp_t q[$];
  logic [7:0] ty = 8'd0, ta = 8'd0, tx = 8'd0;
  logic cur_op = 1'b0;
  logic [15:0] prod, ya, qt, rm;
  logic mul_ok, div_ok;

  always @(posedge CLK) cyc <= cyc + 1;

  // Reference datapath: result is only presented at the exact cycle the sequencer must capture it
  always @(posedge CLK) if (bus.dp_en) k <= (bus.dp_secop == 4'b0000) ? 0 : k + 1;
  always_comb begin
    prod   = {8'd0, ty} * {8'd0, ta};
    ya     = {ty, ta};
    qt     = tx == 8'd0 ? 16'hFFFF : ya / {8'd0, tx};
    rm     = tx == 8'd0 ? 16'h0000 : ya % {8'd0, tx};
    mul_ok = !cur_op && bus.dp_en && bus.dp_secop == 4'b1110 && k == 7;
    div_ok = cur_op && !bus.dp_en && k == 9;
  end
  assign bus.dp_res = mul_ok ? prod : div_ok ? {rm[7:0], qt[7:0]} : (16'hDEAD ^ 16'(k));
  assign bus.dp_zo  = mul_ok ? prod[15:8] == 8'd0 : div_ok ? qt[7:0] == 8'd0 : 1'b1;
  assign bus.dp_vo  = div_ok ? qt > 16'd255 : 1'b1;
  assign bus.dp_ho  = (bus.dp_en && bus.dp_secop == 4'b0000) ? (ty[3:0] >= tx[3:0]) : !(ty[3:0] >= tx[3:0]);

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (bus.done) begin
      done_cnt++;
      if (q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("y_out", int'(bus.y_out), int'(e.y));
        chk("a_out", int'(bus.a_out), int'(e.a));
        chk("flags", int'(bus.flags_out & bus.flags_we), int'(e.f));
        chk("flags_we", int'(bus.flags_we), int'(e.w));
        chk("done_cycle", cyc, e.c);
      end
    end
  end

  task automatic run(input logic o, input logic [7:0] y, a, x, ey, ea,
                     input logic [3:0] ef, ew, input int lat, input bit stall);
    exp_t e;
    ty = y; ta = a; tx = x; cur_op = o;
    @(negedge CLK);
    bus.start = 1'b1; bus.op = o;
    @(negedge CLK);
    bus.start = 1'b0; bus.op = ~o;
    e = '{y: ey, a: ea, f: ef, w: ew, c: cyc + lat - 1};
    q.push_back(e);
    @(negedge CLK);
    bus.start = 1'b1;
    @(negedge CLK);
    bus.start = 1'b0;
    if (stall) begin
      repeat (2) @(negedge CLK);
      CE = 1'b0;
      repeat (3) @(negedge CLK);
      CE = 1'b1;
    end
    for (int i = 0; i < 60 && q.size() != 0; i++) @(negedge CLK);
    if (q.size() != 0) begin
      chk("done_timeout", q.size(), 0);
      q.delete();
    end
    @(negedge CLK);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int dc;
    bus.start = 1'b0; bus.op = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_ya", int'({bus.y_out, bus.a_out}), 0);
    chk("rst_dp", int'({bus.dp_secop, bus.dp_en}), 0);
    RST_N = 1'b1;
    @(negedge CLK);
    run(1'b0, 8'h34, 8'h12, 8'h00, 8'h03, 8'hA8, 4'b0000, 4'b1001, ML, 1'b0);
    // abort a MUL mid-STEP: no done, everything back to zero
    ty = 8'h34; ta = 8'h12; cur_op = 1'b0;
    bus.start = 1'b1; bus.op = 1'b0;
    @(negedge CLK);
    bus.start = 1'b0;
    dc = done_cnt;
    repeat (4) @(negedge CLK);
    chk("busy_mid_step", int'(bus.busy), 1);
    RST_N = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_ya", int'({bus.y_out, bus.a_out}), 0);
    chk("abort_flags", int'({bus.flags_out, bus.flags_we, bus.done}), 0);
    chk("abort_dp", int'({bus.dp_secop, bus.dp_en}), 0);
    repeat (15) @(negedge CLK);
    chk("abort_no_done", done_cnt, dc);
    run(1'b0, 8'h00, 8'h7F, 8'h00, 8'h00, 8'h00, 4'b0001, 4'b1001, ML, 1'b0);
    run(1'b1, 8'h12, 8'h34, 8'h56, 8'h10, 8'h36, 4'b0000, 4'b1111, DL, 1'b0);
    run(1'b1, 8'h11, 8'h00, 8'h10, 8'h00, 8'h10, 4'b0110, 4'b1111, DL, 1'b0);
    run(1'b0, 8'h34, 8'h12, 8'h00, 8'h03, 8'hA8, 4'b0000, 4'b1001, ML + 3, 1'b1);
    run(1'b1, 8'h12, 8'h34, 8'h56, 8'h10, 8'h36, 4'b0000, 4'b1111, DL + 3, 1'b1);
    repeat (3) @(negedge CLK);
    chk("final_busy", int'(bus.busy), 0);
    chk("total_done", done_cnt, 6);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
